// File: rtl/fir_ss_pkg.sv
// rtl/fir_ss_pkg.sv - shared constants for the FIR stream ingress block
package fir_ss_pkg;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] X_OFF      = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CYC_OFF    = 4'h8;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_DROP    = 3;
  localparam int ST_OCC_LSB = 8;
  localparam int ST_POP_LSB = 16;
endpackage

// File: rtl/fir_ss_fifo.sv
// rtl/fir_ss_fifo.sv - synchronous FIFO with wrap-bit pointers and flush
module fir_ss_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_occ
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  // Full/empty come only from registered pointers, so a push while full is
  // refused even if a pop frees a slot on the same edge.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_occ     = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Pointer update; flush discards everything queued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage; contents are don't-care while empty, the consumer gates them.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/fir_ss_ingress.sv
// rtl/fir_ss_ingress.sv - Wishbone-to-stream FIR ingress; FIR_SS_CYCLE_CNT_EN adds block cycle counter
module fir_ss_ingress
  import fir_ss_pkg::*;
#(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0080
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              ap_start_i,
  input  logic [31:0]       data_length_i,
  output logic              ss_tvalid,
  output logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tlast,
  input  logic              ss_tready,
  output logic              done_o
);
  localparam int AW = $clog2(DEPTH);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [31:0]       r_push_cnt;
  logic [31:0]       r_pop_cnt;
  logic              r_done;
  logic              r_drop;

  logic [3:0]        w_off;
  logic              w_req;
  logic              w_x_wr;
  logic              w_over;
  logic              w_full;
  logic              w_empty;
  logic              w_stall;
  logic              w_ack_nxt;
  logic              w_push;
  logic              w_drop;
  logic              w_hs;
  logic [DATA_W:0]   w_head;
  logic [AW:0]       w_occ;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_off     = {wbs_adr_i[3:2], 2'b00};
  assign w_req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_x_wr    = w_req & wbs_we_i & (w_off == X_OFF) & (wbs_sel_i == 4'hF);
  assign w_over    = (r_push_cnt >= data_length_i);
  // Only a write that would actually land in the FIFO waits for space.
  assign w_stall   = w_x_wr & ~w_over & w_full;
  assign w_ack_nxt = w_req & ~r_ack & ~w_stall;
  assign w_push    = w_ack_nxt & w_x_wr & ~w_over & ~ap_start_i;
  assign w_drop    = w_ack_nxt & w_x_wr & w_over;
  assign w_hs      = ss_tvalid & ss_tready;
  assign w_unused  = ^{wbs_adr_i[1:0], r_pop_cnt[31:16]};

  fir_ss_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_flush     (ap_start_i),
    .i_push      (w_push),
    .i_push_data ({(r_push_cnt == data_length_i - 32'd1), wbs_dat_i[DATA_W-1:0]}),
    .i_pop       (w_hs),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occ       (w_occ)
  );

  assign ss_tvalid = ~w_empty;
  assign ss_tdata  = ss_tvalid ? w_head[DATA_W-1:0] : '0;
  assign ss_tlast  = ss_tvalid & w_head[DATA_W];
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign done_o    = r_done;

`ifdef FIR_SS_CYCLE_CNT_EN
  logic [31:0] r_cyc_cnt;
  logic        r_cyc_run;
  logic        r_cyc_frz;

  // Counts from the first handshake of a block through its tlast handshake.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc_cnt <= '0;
      r_cyc_run <= 1'b0;
      r_cyc_frz <= 1'b0;
    end else if (ap_start_i) begin
      r_cyc_cnt <= '0;
      r_cyc_run <= 1'b0;
      r_cyc_frz <= 1'b0;
    end else if (~r_cyc_frz & (r_cyc_run | w_hs)) begin
      if (r_cyc_cnt != 32'hFFFF_FFFF) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_hs & ss_tlast) begin
        r_cyc_frz <= 1'b1;
        r_cyc_run <= 1'b0;
      end else begin
        r_cyc_run <= 1'b1;
      end
    end
  end
`endif

  // Status word and register read mux.
  always_comb begin
    w_status                       = '0;
    w_status[ST_FULL]              = w_full;
    w_status[ST_EMPTY]             = w_empty;
    w_status[ST_DONE]              = r_done;
    w_status[ST_DROP]              = r_drop;
    w_status[ST_OCC_LSB +: 8]      = 8'(w_occ);
    w_status[ST_POP_LSB +: 16]     = r_pop_cnt[15:0];
    w_rdata                        = '0;
    case (w_off)
      STATUS_OFF: w_rdata = w_status;
`ifdef FIR_SS_CYCLE_CNT_EN
      CYC_OFF:    w_rdata = r_cyc_cnt;
`endif
      default:    w_rdata = '0;
    endcase
  end

  // Single-cycle registered ack; read data is valid only alongside the ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_ack_nxt;
      r_dat <= (w_ack_nxt & ~wbs_we_i) ? w_rdata : '0;
    end
  end

  // Block bookkeeping; a new block start overrides every other update.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else if (ap_start_i) begin
      r_push_cnt <= '0;
      r_pop_cnt  <= '0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_push)             r_push_cnt <= r_push_cnt + 32'd1;
      if (w_hs)               r_pop_cnt  <= r_pop_cnt + 32'd1;
      if (w_hs & w_head[DATA_W]) r_done  <= 1'b1;
      if (w_drop)             r_drop     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_ss_ingress.sv
// tb/tb_fir_ss_ingress.sv - randomized self-checking bench for fir_ss_ingress
module tb_fir_ss_ingress;
  import fir_ss_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0080;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ap_start_i;
  logic [31:0] data_length_i;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        done_o;

  always #5 wb_clk_i = ~wb_clk_i;

  fir_ss_ingress #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .ap_start_i    (ap_start_i),
    .data_length_i (data_length_i),
    .ss_tvalid     (ss_tvalid),
    .ss_tdata      (ss_tdata),
    .ss_tlast      (ss_tlast),
    .ss_tready     (ss_tready),
    .done_o        (done_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: the block as a queue of {last, data} plus counters.
  logic [32:0] m_q[$];
  int unsigned m_push_cnt = 0;
  int unsigned m_pop_cnt  = 0;
  bit          m_done     = 0;
  bit          m_drop     = 0;
  int unsigned cyc        = 0;
  int unsigned hs_first   = 0;
  int unsigned hs_last    = 0;
  bit          hs_seen    = 0;
  bit          mon_en     = 0;
  int          tr_mode    = 0;
  logic [31:0] rd_data;

  function automatic logic [31:0] exp_status();
    return {m_pop_cnt[15:0], 8'(m_q.size()), 4'b0000, m_drop, m_done,
            (m_q.size() == 0), (m_q.size() == DEPTH)};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_push_cnt = 0;
    m_pop_cnt  = 0;
    m_done     = 0;
    m_drop     = 0;
    hs_seen    = 0;
    hs_last    = 0;
  endtask

  // Monitor: an acked full-word X write enters the model, handshakes are scored.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge wb_clk_i);
      cyc++;
      if (!wb_rst_i && mon_en) begin
        if (wbs_ack_o && wbs_we_i && wbs_adr_i[3:2] == 2'b00 && wbs_sel_i == 4'hF) begin
          if (m_push_cnt < data_length_i) begin
            m_q.push_back({(m_push_cnt == data_length_i - 32'd1), wbs_dat_i});
            m_push_cnt++;
          end else begin
            m_drop = 1;
          end
        end
        check("tvalid", 32'(ss_tvalid), 32'(m_q.size() != 0));
        if (ss_tvalid && ss_tready) begin
          if (m_q.size() == 0) begin
            check("hs_unexpected", 32'd1, 32'd0);
          end else begin
            e = m_q.pop_front();
            check("tdata", ss_tdata, e[31:0]);
            check("tlast", 32'(ss_tlast), 32'(e[32]));
            m_pop_cnt++;
            if (!hs_seen) begin
              hs_seen  = 1;
              hs_first = cyc;
            end
            if (e[32]) begin
              m_done  = 1;
              hs_last = cyc;
            end
          end
        end
      end
    end
  end

  // Ready driver: 0 hold low, 1 high, 2 random, 3 toggle, other = manual.
  initial begin
    ss_tready = 1'b0;
    forever begin
      @(posedge wb_clk_i); #1;
      case (tr_mode)
        0: ss_tready = 1'b0;
        1: ss_tready = 1'b1;
        2: ss_tready = 1'($urandom % 2);
        3: ss_tready = ~ss_tready;
        default: ;
      endcase
    end
  end

  task automatic wb_begin(input logic [31:0] adr, input logic [31:0] dat, input bit we,
                          input logic [3:0] sel);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
  endtask

  task automatic wb_finish(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        ok      = 1;
        rd_data = wbs_dat_o;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    bit ok;
    wb_begin(BASE | {28'h0, off}, d, 1'b1, sel);
    wb_finish(300, ok);
    check("wr_ack", 32'(ok), 32'd1);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    bit ok;
    wb_begin(BASE | {28'h0, off}, $urandom, 1'b0, 4'hF);
    wb_finish(20, ok);
    check("rd_ack", 32'(ok), 32'd1);
    d = rd_data;
  endtask

  task automatic start_block(input logic [31:0] n);
    tr_mode = 0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    data_length_i = n;
    ap_start_i    = 1'b1;
    @(posedge wb_clk_i); #1;
    ap_start_i    = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int i;
    tr_mode = 1;
    i = 0;
    while ((m_q.size() != 0 || ss_tvalid) && i < 400) begin
      @(posedge wb_clk_i);
      i++;
    end
    check("drain_left", 32'(m_q.size()), 32'd0);
    tr_mode = 0;
    repeat (3) @(posedge wb_clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] v;
    logic [31:0] len;
    int          nwr;
    bit          ok;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; ap_start_i = 0; data_length_i = 0;

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ack",    32'(wbs_ack_o), 32'd0);
    check("rst_dat",    wbs_dat_o,      32'd0);
    check("rst_tvalid", 32'(ss_tvalid), 32'd0);
    check("rst_tdata",  ss_tdata,       32'd0);
    check("rst_tlast",  32'(ss_tlast),  32'd0);
    check("rst_done",   32'(done_o),    32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    mon_en   = 1;
    rd(STATUS_OFF, v);
    check("rst_status", v, 32'h0000_0002);

    // Basic block of four
    start_block(4);
    tr_mode = 1;
    for (int i = 1; i <= 4; i++) wr(X_OFF, 32'(i), 4'hF);
    drain();
    rd(STATUS_OFF, v);
    check("basic_status", v, 32'h0004_0006);
    check("basic_status_m", v, exp_status());
    check("basic_done", 32'(done_o), 32'd1);
`ifndef FIR_SS_CYCLE_CNT_EN
    rd(CYC_OFF, v);
    check("cyc_off_zero", v, 32'd0);
`endif

    // Backpressure: fifth write waits for space
    start_block(8);
    for (int i = 0; i < 4; i++) wr(X_OFF, $urandom, 4'hF);
    wb_begin(BASE, 32'hA5A5_0005, 1'b1, 4'hF);
    repeat (5) begin
      @(negedge wb_clk_i);
      check("stall_noack", 32'(wbs_ack_o), 32'd0);
    end
    tr_mode = 4;
    @(posedge wb_clk_i); #1; ss_tready = 1'b1;
    @(posedge wb_clk_i); #1; ss_tready = 1'b0;
    wb_finish(3, ok);
    check("stall_ack", 32'(ok), 32'd1);
    drain();
    rd(STATUS_OFF, v);
    check("bp_status", v, 32'h0005_0002);

    // Overflow: third write dropped
    start_block(2);
    tr_mode = 1;
    for (int i = 0; i < 3; i++) wr(X_OFF, $urandom, 4'hF);
    drain();
    rd(STATUS_OFF, v);
    check("ovf_status", v, 32'h0002_000E);
    check("ovf_status_m", v, exp_status());

    // Zero length: everything dropped, never done
    start_block(0);
    tr_mode = 1;
    wr(X_OFF, 32'h1111_1111, 4'hF);
    wr(X_OFF, 32'h2222_2222, 4'hF);
    drain();
    rd(STATUS_OFF, v);
    check("len0_status", v, 32'h0000_000A);

    // Flush mid-block
    start_block(8);
    tr_mode = 1;
    wr(X_OFF, $urandom, 4'hF);
    wr(X_OFF, $urandom, 4'hF);
    drain();
    for (int i = 0; i < 3; i++) wr(X_OFF, $urandom, 4'hF);
    rd(STATUS_OFF, v);
    check("pre_flush_status", v, 32'h0002_0300);
    start_block(8);
    @(negedge wb_clk_i);
    check("flush_tvalid", 32'(ss_tvalid), 32'd0);
    rd(STATUS_OFF, v);
    check("flush_status", v, 32'h0000_0002);

    // Other registers and a non-decoded address
    rd(X_OFF, v);
    check("x_read_zero", v, 32'd0);
    rd(4'hC, v);
    check("rsvd_read_zero", v, 32'd0);
    wb_begin(32'h3000_0000, 32'hDEAD_BEEF, 1'b1, 4'hF);
    wb_finish(5, ok);
    check("miss_noack", 32'(ok), 32'd0);

    // Randomized blocks
    for (int b = 0; b < 12; b++) begin
      len = 32'($urandom_range(0, 9));
      nwr = int'(len) + int'($urandom_range(0, 2));
      start_block(len);
      tr_mode = 2;
      for (int i = 0; i < nwr; i++) begin
        if ($urandom % 8 == 0)      wr(X_OFF, $urandom, 4'h3);
        else if ($urandom % 8 == 0) wr(4'hC, $urandom, 4'hF);
        else                        wr(X_OFF, $urandom, 4'hF);
      end
      drain();
      rd(STATUS_OFF, v);
      check("rand_status", v, exp_status());
      check("rand_done", 32'(done_o), 32'(m_done));
    end

`ifdef FIR_SS_CYCLE_CNT_EN
    // Cycle counter over a 64-sample block with alternating ready
    start_block(64);
    tr_mode = 3;
    for (int i = 0; i < 64; i++) wr(X_OFF, $urandom, 4'hF);
    drain();
    rd(CYC_OFF, v);
    check("cyc_cnt", v, 32'(hs_last - hs_first + 1));
`endif

    // Reset while streaming with an ack outstanding
    start_block(8);
    wr(X_OFF, $urandom, 4'hF);
    wr(X_OFF, $urandom, 4'hF);
    wb_begin(BASE | {28'h0, STATUS_OFF}, 32'h0, 1'b0, 4'hF);
    @(posedge wb_clk_i); #2;
    check("pre_rst_ack", 32'(wbs_ack_o), 32'd1);
    wb_rst_i = 1'b1;
    model_clear();
    #1;
    check("mid_rst_ack",    32'(wbs_ack_o), 32'd0);
    check("mid_rst_dat",    wbs_dat_o,      32'd0);
    check("mid_rst_tvalid", 32'(ss_tvalid), 32'd0);
    check("mid_rst_tdata",  ss_tdata,       32'd0);
    check("mid_rst_done",   32'(done_o),    32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    repeat (4) begin
      @(negedge wb_clk_i);
      check("post_rst_noack", 32'(wbs_ack_o), 32'd0);
    end
    rd(STATUS_OFF, v);
    check("post_rst_status", v, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
